// File: rtl/bit_pattern_tx.sv
// bit_pattern_tx
// Serial pattern transmitter. Latches a WIDTH-bit pattern on an accepted
// start and shifts it out MSB-first on B, one bit per clock. It can repeat
// the pattern, with GAP idle bit-times between copies. After the last bit
// of the last copy it pulses done for one cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | B=IDLE_BIT, valid=0, busy=0; start is only accepted here
//   SEND  | B carries pattern bit bit_cnt (WIDTH-1 down to 0)
//   GAP   | B=IDLE_BIT, valid=0, busy=1; gap_cnt counts down to reload
//
// Every output comes from a flop. The next-state logic reads the inputs
// only in IDLE, so no input reaches an output combinationally.
module bit_pattern_tx #(
  parameter int WIDTH    = 8,
  parameter int REP_W    = 4,
  parameter int GAP      = 1,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             B,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  // With GAP=0 the GAP state is unreachable. The load value is then a harmless 0.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [WIDTH-1:0] shreg_q, shreg_n;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_n;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_n;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_n;
  logic             b_n, valid_n, busy_n, done_n;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_n   = state_q;
    pat_n     = pat_q;
    shreg_n   = shreg_q;
    bit_cnt_n = bit_cnt_q;
    rep_cnt_n = rep_cnt_q;
    gap_cnt_n = gap_cnt_q;
    b_n       = B;
    valid_n   = valid;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        b_n     = IDLE_BIT;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (start) begin
          // The MSB goes out on this edge. The shifter holds the remaining bits.
          pat_n     = pattern;
          shreg_n   = pattern << 1;
          b_n       = pattern[WIDTH-1];
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          bit_cnt_n = BIT_LAST;
          rep_cnt_n = (reps == '0) ? '0 : reps - REP_W'(1);
          gap_cnt_n = '0;
          state_n   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (bit_cnt_q != '0) begin
          b_n       = shreg_q[WIDTH-1];
          shreg_n   = shreg_q << 1;
          bit_cnt_n = bit_cnt_q - BW'(1);
        end else if (rep_cnt_q != '0) begin
          rep_cnt_n = rep_cnt_q - REP_W'(1);
          if (GAP > 0) begin
            b_n       = IDLE_BIT;
            valid_n   = 1'b0;
            gap_cnt_n = GAP_LOAD;
            state_n   = ST_GAP;
          end else begin
            // Back-to-back copies: reload with no bubble.
            b_n       = pat_q[WIDTH-1];
            shreg_n   = pat_q << 1;
            bit_cnt_n = BIT_LAST;
          end
        end else begin
          b_n     = IDLE_BIT;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          b_n       = pat_q[WIDTH-1];
          shreg_n   = pat_q << 1;
          bit_cnt_n = BIT_LAST;
          valid_n   = 1'b1;
          state_n   = ST_SEND;
        end else begin
          gap_cnt_n = gap_cnt_q - GW'(1);
        end
      end

      default: begin
        b_n     = IDLE_BIT;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, including start.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      B         <= IDLE_BIT;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      pat_q     <= pat_n;
      shreg_q   <= shreg_n;
      bit_cnt_q <= bit_cnt_n;
      rep_cnt_q <= rep_cnt_n;
      gap_cnt_q <= gap_cnt_n;
      B         <= b_n;
      valid     <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// Directed bench for bit_pattern_tx. u0 has WIDTH=4 and GAP=1. u1 has
// WIDTH=4 and GAP=0. Both instances share the same stimulus.
module tb_bit_pattern_tx;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       b0, v0, y0, d0;
  logic       b1, v1, y1, d1;

  int checks = 0;
  int errors = 0;

  logic [8:0]  exp_b9, exp_v9;
  logic [11:0] exp_b12;
  logic [3:0]  exp_b4;

  bit_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(1), .IDLE_BIT(1'b0)) u0 (
    .Clk(Clk), .Rst(Rst), .start(start), .pattern(pattern), .reps(reps),
    .B(b0), .valid(v0), .busy(y0), .done(d0)
  );

  bit_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(0), .IDLE_BIT(1'b0)) u1 (
    .Clk(Clk), .Rst(Rst), .start(start), .pattern(pattern), .reps(reps),
    .B(b1), .valid(v1), .busy(y1), .done(d1)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic eb, input logic ev,
                      input logic ey, input logic ed);
    chk({tag, ".B"}, b0, eb);
    chk({tag, ".valid"}, v0, ev);
    chk({tag, ".busy"}, y0, ey);
    chk({tag, ".done"}, d0, ed);
  endtask

  task automatic chk1(input string tag, input logic eb, input logic ev,
                      input logic ey, input logic ed);
    chk({tag, ".B"}, b1, eb);
    chk({tag, ".valid"}, v1, ev);
    chk({tag, ".busy"}, y1, ey);
    chk({tag, ".done"}, d1, ed);
  endtask

  initial begin
    // 1. Reset held with start asserted.
    Rst = 1'b1; start = 1'b1; pattern = 4'hF; reps = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0($sformatf("rst_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk1($sformatf("rst_hold%0d_g0", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    Rst = 1'b0; start = 1'b0;
    tick();
    chk0("idle_after_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Single copy, reps=0 treated as 1.
    pattern = 4'b1101; reps = 4'd0; start = 1'b1;
    exp_b4 = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      chk0($sformatf("single_bit%0d", i), exp_b4[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk0("single_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk0("single_after_done", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3. Two copies with one gap bit on u0; u1 runs them back-to-back.
    pattern = 4'b1011; reps = 4'd2; start = 1'b1;
    exp_b9 = 9'b1011_0_1011;
    exp_v9 = 9'b1111_0_1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      start = 1'b0;
      chk0($sformatf("gap_bit%0d", i), exp_b9[8-i], exp_v9[8-i], 1'b1, 1'b0);
      if (i == 8) chk1("g0_rep2_done", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk0("gap_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // 4. GAP=0 instance, three copies are contiguous.
    pattern = 4'b1001; reps = 4'd3; start = 1'b1;
    exp_b12 = 12'b1001_1001_1001;
    for (int i = 0; i < 12; i++) begin
      tick();
      start = 1'b0;
      chk1($sformatf("g0_bit%0d", i), exp_b12[11-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk1("g0_done", 1'b0, 1'b0, 1'b0, 1'b1);
    chk0("g1_still_busy", 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk0("g1_rep3_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // 5. Reset at the edge ending the second bit, then restart at once.
    pattern = 4'b1101; reps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk0("abort_bit0", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk0("abort_bit1", 1'b1, 1'b1, 1'b1, 1'b0);
    Rst = 1'b1;
    tick();
    chk0("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b0; pattern = 4'b1010; start = 1'b1;
    exp_b4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b0;
      chk0($sformatf("restart_bit%0d", i), exp_b4[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk0("restart_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // 6. start held high: no re-latch while busy, accepted in the done cycle.
    pattern = 4'b0110; reps = 4'd0; start = 1'b1;
    exp_b4 = 4'b0110;
    tick();
    chk0("hold_bit0", exp_b4[3], 1'b1, 1'b1, 1'b0);
    pattern = 4'b1111;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk0($sformatf("hold_bit%0d", i), exp_b4[3-i], 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk0("hold_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    pattern = 4'b0000;
    chk0("b2b_bit0", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk0($sformatf("b2b_bit%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    tick();
    chk0("b2b_done", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk0("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
